// File: rtl/sram_seq.sv
// SRAM access sequencer: turns MAR/MDR read/write requests into timed
// async-SRAM strobe sequences, with address 16'hFFFF mapped to switches/hex.
module sram_seq #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] switches,
    input  logic [15:0] dq_in,
    output logic [15:0] rdata,
    output logic        done,
    output logic        busy,
    output logic [19:0] sram_addr,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        UB_N,
    output logic        LB_N,
    output logic [15:0] hex_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        IO_DONE
    } state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [15:0] IO_ADDR   = 16'hFFFF;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       last_q;

    // Down-counter saturates at 1 so it can never wrap past zero.
    always_comb begin
        cnt_d  = (cnt_q > 4'd1) ? cnt_q - 4'd1 : 4'd1;
        last_q = (cnt_q <= 4'd1);
    end

    // Sequencer FSM; every output is a flop so no input reaches an output.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd1;
            rdata     <= 16'h0000;
            hex_out   <= 16'h0000;
            sram_addr <= 20'h00000;
            dq_out    <= 16'h0000;
            dq_oe     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            CE_N      <= 1'b1;
            OE_N      <= 1'b1;
            WE_N      <= 1'b1;
            UB_N      <= 1'b1;
            LB_N      <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (req_rd || req_wr) begin
                        busy      <= 1'b1;
                        sram_addr <= {4'h0, addr};
                        if (addr == IO_ADDR) begin
                            state_q <= IO_DONE;
                            done    <= 1'b1;
                            if (req_rd) begin
                                rdata <= switches;
                            end else begin
                                hex_out <= wdata;
                            end
                        end else if (req_rd) begin
                            state_q <= RD_WAIT;
                            cnt_q   <= WAIT_INIT;
                            CE_N    <= 1'b0;
                            OE_N    <= 1'b0;
                            UB_N    <= 1'b0;
                            LB_N    <= 1'b0;
                        end else begin
                            state_q <= WR_SETUP;
                            dq_out  <= wdata;
                            dq_oe   <= 1'b1;
                            CE_N    <= 1'b0;
                            UB_N    <= 1'b0;
                            LB_N    <= 1'b0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (last_q) begin
                        state_q <= RD_DONE;
                        rdata   <= dq_in;
                        done    <= 1'b1;
                        CE_N    <= 1'b1;
                        OE_N    <= 1'b1;
                        UB_N    <= 1'b1;
                        LB_N    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RD_DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    cnt_q   <= WAIT_INIT;
                    WE_N    <= 1'b0;
                end
                WR_PULSE: begin
                    if (last_q) begin
                        state_q <= WR_HOLD;
                        WE_N    <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WR_HOLD: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    dq_oe   <= 1'b0;
                    CE_N    <= 1'b1;
                    UB_N    <= 1'b1;
                    LB_N    <= 1'b1;
                end
                IO_DONE: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_seq.sv
// Randomised scoreboard bench for sram_seq with a behavioural SRAM
// and an abstract memory/latency model of each transaction.
module tb_sram_seq;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [15:0] switches = 16'h0;
    logic [15:0] dq_in;
    logic [15:0] rdata;
    logic        done;
    logic        busy;
    logic [19:0] sram_addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        CE_N, OE_N, WE_N, UB_N, LB_N;
    logic [15:0] hex_out;

    sram_seq #(.WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .switches(switches), .dq_in(dq_in),
        .rdata(rdata), .done(done), .busy(busy), .sram_addr(sram_addr),
        .dq_out(dq_out), .dq_oe(dq_oe), .CE_N(CE_N), .OE_N(OE_N),
        .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N), .hex_out(hex_out)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        string       name;
        int          issue;
        int          lat;
        int          oe;
        int          we;
        int          ce;
        logic [15:0] a;
        logic [15:0] rdata;
        logic [15:0] hex;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] ref_mem [0:255];
    logic [15:0] sram_mem [0:255];
    logic [15:0] last_rd = 16'h0;
    logic [15:0] last_hex = 16'h0;

    function automatic logic [15:0] init_val(input logic [7:0] i);
        return {~i, i} ^ 16'h3C00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    assign dq_in = (!CE_N && !OE_N) ? sram_mem[sram_addr[7:0]] : 16'hDEAD;

    // Behavioural SRAM: stores dq_out every cycle WE_N is low with the chip selected.
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = init_val(8'(i));
        sram_mem[8'h10] = 16'hBEEF;
        forever begin
            @(posedge Clk);
            if (!WE_N && !CE_N && dq_oe) sram_mem[sram_addr[7:0]] = dq_out;
        end
    end

    int oe_n = 0;
    int we_n = 0;
    int ce_n = 0;

    // Monitor: counts strobe cycles and checks each done pulse against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                oe_n = 0;
                we_n = 0;
                ce_n = 0;
            end else begin
                if (!OE_N) oe_n++;
                if (!WE_N) we_n++;
                if (!CE_N) ce_n++;
                if (!WE_N) chk("we_low_needs_oe", 32'(dq_oe), 1);
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", 32'(done), 0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
                        chk({e.name, "_oe_cycles"}, 32'(oe_n), 32'(e.oe));
                        chk({e.name, "_we_cycles"}, 32'(we_n), 32'(e.we));
                        chk({e.name, "_ce_cycles"}, 32'(ce_n), 32'(e.ce));
                        chk({e.name, "_rdata"}, 32'(rdata), 32'(e.rdata));
                        chk({e.name, "_hex_out"}, 32'(hex_out), 32'(e.hex));
                        chk({e.name, "_sram_addr"}, 32'(sram_addr), {12'h0, 4'h0, e.a});
                    end
                    oe_n = 0;
                    we_n = 0;
                    ce_n = 0;
                end
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] sw, input logic bounce);
        exp_t e;
        int   t = 0;
        while (busy && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 0);
        e.issue = cyc;
        e.a     = a;
        e.oe    = 0;
        e.we    = 0;
        e.ce    = 0;
        if (rd) begin
            e.name = "read";
            if (a == 16'hFFFF) begin
                last_rd = sw;
                e.lat   = 1;
            end else begin
                last_rd = ref_mem[a[7:0]];
                e.lat   = W + 1;
                e.oe    = W;
                e.ce    = W;
            end
        end else begin
            e.name = "write";
            if (a == 16'hFFFF) begin
                last_hex = d;
                e.lat    = 1;
            end else begin
                ref_mem[a[7:0]] = d;
                e.lat = W + 2;
                e.we  = W;
                e.ce  = W + 2;
            end
        end
        e.rdata = last_rd;
        e.hex   = last_hex;
        sb.push_back(e);
        req_rd   = rd;
        req_wr   = wr;
        addr     = a;
        wdata    = d;
        switches = sw;
        @(negedge Clk);
        req_rd   = 1'b0;
        req_wr   = bounce;
        addr     = 16'($urandom);
        wdata    = 16'($urandom);
        switches = 16'($urandom);
        @(negedge Clk);
        req_wr = 1'b0;
    endtask

    initial begin
        int t;
        logic [15:0] a;
        logic rd, wr;
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        logic [15:0] a;
        logic rd, wr;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        ref_mem[8'h10] = 16'hBEEF;
        #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_hex", 32'(hex_out), 0);
        chk("rst_sram_addr", 32'(sram_addr), 0);
        chk("rst_done_busy", {30'h0, done, busy}, 0);
        chk("rst_dq", {15'h0, dq_oe, dq_out}, 0);
        chk("rst_strobes", {27'h0, CE_N, OE_N, WE_N, UB_N, LB_N}, 32'h1F);
        Reset = 1'b1;
        @(negedge Clk);

        issue(1'b1, 1'b0, 16'h0010, 16'h0, 16'h0, 1'b0);
        issue(1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0, 1'b0);
        issue(1'b1, 1'b0, 16'h0020, 16'h0, 16'h0, 1'b0);
        issue(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 16'h0, 1'b0);
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0, 16'h0F0F, 1'b0);
        issue(1'b1, 1'b1, 16'h0005, 16'h7777, 16'h0, 1'b1);
        issue(1'b1, 1'b0, 16'h0005, 16'h0, 16'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 9));
            a  = (k == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            issue(rd, wr, a, 16'($urandom), 16'($urandom), 1'($urandom));
        end

        t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("drain_before_reset", 32'(sb.size()), 0);

        req_wr = 1'b1;
        addr   = 16'h00F0;
        wdata  = 16'hA5A5;
        @(negedge Clk);
        req_wr = 1'b0;
        t = 0;
        while (WE_N && t < 20) begin
            @(negedge Clk);
            t++;
        end
        chk("reached_we_pulse", 32'(WE_N), 0);
        #2 Reset = 1'b0;
        #1;
        chk("abort_we_n", 32'(WE_N), 1);
        chk("abort_dq_oe", 32'(dq_oe), 0);
        chk("abort_ce_n", 32'(CE_N), 1);
        chk("abort_done", 32'(done), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rdata", 32'(rdata), 0);
        last_rd  = 16'h0;
        last_hex = 16'h0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        issue(1'b1, 1'b0, 16'h0003, 16'h0, 16'h0, 1'b0);
        issue(1'b0, 1'b1, 16'h0003, 16'h4321, 16'h0, 1'b0);
        issue(1'b1, 1'b0, 16'h0003, 16'h0, 16'h0, 1'b0);

        t = 0;
        while ((busy || sb.size() != 0) && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("drain_final", 32'(sb.size()), 0);
        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
